// File: rtl/uart_rx.sv
// UART receiver: recovers one WORD_SIZE-bit word per frame (start, data LSB
// first, stop) and hands it to a consumer through a one-entry valid/ready
// holding register. Stop-bit errors and dropped words are reported as pulses.
`timescale 1ns/1ps

module uart_rx #(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [WORD_SIZE-1:0] data_bits_rx,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(PULSE_WIDTH / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rxState_e;

  logic                 rxMeta_q;
  logic                 rxSync_q;
  rxState_e             state_q;
  logic [CW-1:0]        cyc_q;
  logic [BW-1:0]        bitIdx_q;
  logic [WORD_SIZE-1:0] shift_q;
  logic [WORD_SIZE-1:0] word_q;
  logic                 deliver_q;
  logic                 frameErr_q;

  logic [WORD_SIZE-1:0] holdData_q, holdData_d;
  logic                 holdValid_q, holdValid_d;
  logic                 overrun_q, overrun_d;

  // Two-flop synchronizer; the line idles high so both flops reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // Frame FSM: finds the start edge, samples each bit at its centre and
  // checks the stop bit; a finished good word is handed over via deliver_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      deliver_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      deliver_q  <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cyc_q <= '0;
          if (!rxSync_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (cyc_q == HALF_LAST) begin
            cyc_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? IDLE : DATA;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q   <= '0;
            shift_q <= {rxSync_q, shift_q[WORD_SIZE-1:1]};
            if (bitIdx_q == BIT_LAST) begin
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        STOP: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (rxSync_q) begin
              word_q    <= shift_q;
              deliver_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= WAIT_IDLE;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          cyc_q <= '0;
          if (rxSync_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= '0;
        end
      endcase
    end
  end

  // Holding register next state: load when empty or being drained this
  // cycle, otherwise drop the new word and flag an overrun.
  always_comb begin
    holdData_d  = holdData_q;
    holdValid_d = holdValid_q;
    overrun_d   = 1'b0;
    if (deliver_q) begin
      if (!holdValid_q || rx_ready) begin
        holdData_d  = word_q;
        holdValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (holdValid_q && rx_ready) begin
      holdValid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdData_q  <= '0;
      holdValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      holdData_q  <= holdData_d;
      holdValid_q <= holdValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_bits_rx = holdData_q;
  assign rx_valid     = holdValid_q;
  assign frame_err    = frameErr_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default instance (4 clk/bit) for the scenario
// tests, plus an 8 clk/bit instance fed by a behavioural transmitter.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int PW   = 4;
  localparam int PW8  = 8;
  localparam int HALF = PW / 2;
  localparam int LAT  = 41;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rxReady = 1'b0;
  logic [7:0] dataBitsRx;
  logic       rxValid, frameErr, overrun, busy;

  logic       rx8 = 1'b1;
  logic       rxReady8 = 1'b0;
  logic [7:0] data8;
  logic       valid8, ferr8, ovr8, busy8;

  int total = 0;
  int bad = 0;

  int cycleCnt = 0;
  int startEdge = 0;

  int validRises = 0;
  int validHigh = 0;
  int lastLatency = 0;
  logic [7:0] lastData = '0;
  int ferrCnt = 0;
  int ovrCnt = 0;
  int bothCnt = 0;
  int busyRun = 0;
  int lastBusyRun = 0;
  int busyRunsDone = 0;
  logic prevValid = 1'b0;
  logic [7:0] accQ[$];

  logic [7:0] acc8[$];
  int ferr8Cnt = 0;
  int ovr8Cnt = 0;
  int both8Cnt = 0;

  uart_rx #(.WORD_SIZE(8), .PULSE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rxReady),
    .data_bits_rx(dataBitsRx), .rx_valid(rxValid),
    .frame_err(frameErr), .overrun(overrun), .busy(busy)
  );

  uart_rx #(.WORD_SIZE(8), .PULSE_WIDTH(PW8)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_ready(rxReady8),
    .data_bits_rx(data8), .rx_valid(valid8),
    .frame_err(ferr8), .overrun(ovr8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // Counts active edges so frame latency can be measured in cycles.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Observes the default instance between edges and accumulates events.
  always @(negedge clk) begin
    if (rxValid && !prevValid) begin
      validRises  <= validRises + 1;
      lastLatency <= cycleCnt - startEdge;
      lastData    <= dataBitsRx;
    end
    if (rxValid) validHigh <= validHigh + 1;
    if (rxValid && rxReady) accQ.push_back(dataBitsRx);
    if (frameErr) ferrCnt <= ferrCnt + 1;
    if (overrun) ovrCnt <= ovrCnt + 1;
    if (frameErr && overrun) bothCnt <= bothCnt + 1;
    if (busy) begin
      busyRun <= busyRun + 1;
    end else if (busyRun > 0) begin
      lastBusyRun  <= busyRun;
      busyRunsDone <= busyRunsDone + 1;
      busyRun      <= 0;
    end
    prevValid <= rxValid;
  end

  // Observes the 8 clk/bit instance.
  always @(negedge clk) begin
    if (valid8 && rxReady8) acc8.push_back(data8);
    if (ferr8) ferr8Cnt <= ferr8Cnt + 1;
    if (ovr8) ovr8Cnt <= ovr8Cnt + 1;
    if (ferr8 && ovr8) both8Cnt <= both8Cnt + 1;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic driveBit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    driveBit(1'b1, n);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    startEdge = cycleCnt + 1;
    driveBit(1'b0, PW);
    for (int i = 0; i < 8; i++) driveBit(d[i], PW);
    driveBit(stopBit, PW);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rxReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    total++; if (dataBitsRx !== 8'h00) begin bad++; $display("[TB] FAIL reset data: got %h want 00", dataBitsRx); end
    total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL reset valid: got %b want 0", rxValid); end
    total++; if (frameErr !== 1'b0) begin bad++; $display("[TB] FAIL reset frame_err: got %b want 0", frameErr); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset overrun: got %b want 0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int r0, h0, f0, o0;
    rxReady = 1'b1;
    r0 = validRises; h0 = validHigh; f0 = ferrCnt; o0 = ovrCnt;
    sendFrame(8'hA5, 1'b1);
    idle(8);
    total++; if (validRises - r0 !== 1) begin bad++; $display("[TB] FAIL single rises: got %0d want 1", validRises - r0); end
    total++; if (lastLatency !== LAT) begin bad++; $display("[TB] FAIL single latency: got %0d want %0d", lastLatency, LAT); end
    total++; if (lastData !== 8'hA5) begin bad++; $display("[TB] FAIL single data: got %h want a5", lastData); end
    total++; if (validHigh - h0 !== 1) begin bad++; $display("[TB] FAIL single valid width: got %0d want 1", validHigh - h0); end
    total++; if ((ferrCnt - f0) + (ovrCnt - o0) !== 0) begin bad++; $display("[TB] FAIL single flags: got %0d want 0", (ferrCnt - f0) + (ovrCnt - o0)); end
  endtask

  task automatic test_back_to_back();
    int f0, o0;
    rxReady = 1'b0;
    f0 = ferrCnt; o0 = ovrCnt;
    sendFrame(8'h3C, 1'b1);
    sendFrame(8'hC3, 1'b1);
    idle(8);
    total++; if (ovrCnt - o0 !== 1) begin bad++; $display("[TB] FAIL b2b overrun pulses: got %0d want 1", ovrCnt - o0); end
    total++; if (rxValid !== 1'b1) begin bad++; $display("[TB] FAIL b2b held valid: got %b want 1", rxValid); end
    total++; if (dataBitsRx !== 8'h3C) begin bad++; $display("[TB] FAIL b2b held data: got %h want 3c", dataBitsRx); end
    total++; if (ferrCnt - f0 !== 0) begin bad++; $display("[TB] FAIL b2b frame_err: got %0d want 0", ferrCnt - f0); end
    rxReady = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b valid after accept: got %b want 0", rxValid); end
    total++; if (accQ.size() == 0 || accQ[$] !== 8'h3C) begin bad++; $display("[TB] FAIL b2b accepted word: got %h want 3c", (accQ.size() == 0) ? 8'hxx : accQ[$]); end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    rxReady = 1'b1;
    r0 = validRises; f0 = ferrCnt;
    sendFrame(8'h81, 1'b0);
    driveBit(1'b0, 20 * PW);
    idle(8);
    total++; if (ferrCnt - f0 !== 1) begin bad++; $display("[TB] FAIL break frame_err pulses: got %0d want 1", ferrCnt - f0); end
    total++; if (validRises - r0 !== 0) begin bad++; $display("[TB] FAIL break valid rises: got %0d want 0", validRises - r0); end
    sendFrame(8'h55, 1'b1);
    idle(8);
    total++; if (validRises - r0 !== 1) begin bad++; $display("[TB] FAIL recover rises: got %0d want 1", validRises - r0); end
    total++; if (lastData !== 8'h55) begin bad++; $display("[TB] FAIL recover data: got %h want 55", lastData); end
    total++; if (lastLatency !== LAT) begin bad++; $display("[TB] FAIL recover latency: got %0d want %0d", lastLatency, LAT); end
    total++; if (ferrCnt - f0 !== 1) begin bad++; $display("[TB] FAIL recover frame_err: got %0d want 1", ferrCnt - f0); end
  endtask

  task automatic test_glitch();
    int r0, f0, o0, b0;
    r0 = validRises; f0 = ferrCnt; o0 = ovrCnt; b0 = busyRunsDone;
    driveBit(1'b0, 1);
    idle(12);
    total++; if (busyRunsDone - b0 !== 1) begin bad++; $display("[TB] FAIL glitch busy runs: got %0d want 1", busyRunsDone - b0); end
    total++; if (!(lastBusyRun >= 1 && lastBusyRun <= HALF + 2)) begin bad++; $display("[TB] FAIL glitch busy length: got %0d want 1..%0d", lastBusyRun, HALF + 2); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch busy now: got %b want 0", busy); end
    total++; if ((validRises - r0) + (ferrCnt - f0) + (ovrCnt - o0) !== 0) begin bad++; $display("[TB] FAIL glitch events: got %0d want 0", (validRises - r0) + (ferrCnt - f0) + (ovrCnt - o0)); end
  endtask

  task automatic test_reset_mid();
    int r0, f0, o0;
    rxReady = 1'b1;
    startEdge = cycleCnt + 1;
    driveBit(1'b0, PW);
    driveBit(1'b1, 4 * PW + 2);
    rst = 1'b1;
    #1;
    total++; if (dataBitsRx !== 8'h00) begin bad++; $display("[TB] FAIL midreset data: got %h want 00", dataBitsRx); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset busy: got %b want 0", busy); end
    total++; if ({rxValid, frameErr, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL midreset flags: got %b want 000", {rxValid, frameErr, overrun}); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = validRises; f0 = ferrCnt; o0 = ovrCnt;
    idle(4 * PW);
    total++; if ({rxValid, busy} !== 2'b00) begin bad++; $display("[TB] FAIL after reset idle: got %b want 00", {rxValid, busy}); end
    sendFrame(8'h12, 1'b1);
    idle(8);
    total++; if (validRises - r0 !== 1) begin bad++; $display("[TB] FAIL post-reset rises: got %0d want 1", validRises - r0); end
    total++; if (lastData !== 8'h12) begin bad++; $display("[TB] FAIL post-reset data: got %h want 12", lastData); end
    total++; if ((ferrCnt - f0) + (ovrCnt - o0) !== 0) begin bad++; $display("[TB] FAIL post-reset flags: got %0d want 0", (ferrCnt - f0) + (ovrCnt - o0)); end
  endtask

  task automatic test_stream();
    logic [9:0] frame;
    int wrong;
    for (int w = 0; w < 256; w++) begin
      frame = {1'b1, 8'(w), 1'b0};
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < PW8; c++) begin
          rx8 = frame[b];
          rxReady8 = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    end
    rx8 = 1'b1;
    rxReady8 = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    wrong = 0;
    for (int i = 0; i < acc8.size() && i < 256; i++) begin
      if (acc8[i] !== 8'(i)) wrong++;
    end
    total++; if (acc8.size() !== 256) begin bad++; $display("[TB] FAIL stream count: got %0d want 256", acc8.size()); end
    total++; if (wrong !== 0) begin bad++; $display("[TB] FAIL stream order: got %0d wrong words want 0", wrong); end
    total++; if (ferr8Cnt !== 0) begin bad++; $display("[TB] FAIL stream frame_err: got %0d want 0", ferr8Cnt); end
    total++; if (ovr8Cnt !== 0) begin bad++; $display("[TB] FAIL stream overrun: got %0d want 0", ovr8Cnt); end
    total++; if (bothCnt + both8Cnt !== 0) begin bad++; $display("[TB] FAIL flags coincide: got %0d want 0", bothCnt + both8Cnt); end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    $display("[TB] uart_rx bench start");
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
